// File: rtl/fpu_div_ctrl.sv
// ============================================================================
//  Module   : fpu_div_ctrl
//  Purpose  : Round-robin arbiter and sequencer for the shared iterative
//             FP divide/sqrt unit, with redirect squash at every stage.
//             Optional macro FDIV_EARLY_KILL_EN aborts squashed ops early.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package fpu_div_pkg;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;

    typedef struct packed {
        logic [15:0]      opid;
        logic [7:0]       brid;
        logic [7:0]       ldid;
        logic [7:0]       stid;
        logic [63:0]      pc;
        logic [7:0]       pat;
        logic [63:0]      delta;
        logic [63:0]      base;
        logic [1:0][7:0]  prda;
    } reg_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [7:0]  brid;
        logic [7:0]  ldid;
        logic [7:0]  stid;
        logic [63:0] pc;
        logic [7:0]  pat;
        logic [63:0] delta;
        logic [7:0]  prda;
        logic [63:0] npc;
        logic [63:0] prdv;
    } exe_bundle_t;

endpackage

module fpu_div_ctrl
    import fpu_div_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int OPSZ = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  red_bundle_t              redir,
    input  logic [NREQ-1:0]          req_valid,
    input  reg_bundle_t [NREQ-1:0]   req,
    output logic [NREQ-1:0]          req_ready,
    output logic                     unit_start,
    output reg_bundle_t              unit_op,
    input  logic                     unit_done,
    input  logic [63:0]              unit_value,
    output logic                     unit_kill,
    input  logic                     claim,
    output exe_bundle_t              resp
);

    localparam int c_lw = $clog2(OPSZ);
    localparam int c_pw = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_lw-1:0] c_one = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
`ifndef FDIV_EARLY_KILL_EN
        S_DRAIN = 3'd3,
`endif
        S_HOLD  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_pw-1:0]   r_rr_ptr;
    logic [c_pw-1:0]   w_rr_next;
    reg_bundle_t       r_unit_op;
    exe_bundle_t       r_resp;
    exe_bundle_t       w_resp_new;

    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_grant;
    logic [c_pw-1:0]   w_grant_idx;
    logic              w_found;
    logic              w_sq_op;
    logic              w_sq_resp;
    logic              w_accept;
    logic              w_latch;
    logic              w_clr;
    state_t            w_sq_target;
    logic              w_unused;

    // Younger-than-redirect test on the low opid bits, modulo the ID space,
    // measured relative to the redirect's oldest outstanding op (topid).
    function automatic logic f_squash(input logic [15:0] x, input red_bundle_t r);
        logic [c_lw-1:0] dx;
        logic [c_lw-1:0] dr;
        dx = x[c_lw-1:0] - r.topid[c_lw-1:0];
        dr = r.opid[c_lw-1:0] - r.topid[c_lw-1:0] + c_one;
        return r.opid[15] & x[15] & (dx >= dr);
    endfunction

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_elig
            assign w_elig[i] = req_valid[i] & req[i].opid[15] & ~f_squash(req[i].opid, redir);
        end
    endgenerate

    assign w_sq_op   = f_squash(r_unit_op.opid, redir);
    assign w_sq_resp = f_squash(r_resp.opid, redir);

    always_comb begin
        int idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && w_elig[idx]) begin
                w_found          = 1'b1;
                w_grant[idx]     = 1'b1;
                w_grant_idx      = c_pw'(idx);
            end
        end
    end

    always_comb begin
        if (w_grant_idx == c_pw'(NREQ - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_grant_idx + c_pw'(1);
        end
    end

    // Where a squashed in-flight op goes: straight home when the unit can be
    // aborted or its result is arriving this very cycle, otherwise drain it.
`ifdef FDIV_EARLY_KILL_EN
    assign w_sq_target = S_IDLE;
`else
    assign w_sq_target = unit_done ? S_IDLE : S_DRAIN;
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_latch  = 1'b0;
        w_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next   = S_START;
                    w_accept = 1'b1;
                end
            end
            S_START: begin
                if (w_sq_op) begin
`ifdef FDIV_EARLY_KILL_EN
                    w_next = S_IDLE;
`else
                    w_next = S_DRAIN;
`endif
                end else begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_sq_op) begin
                    w_next = w_sq_target;
                end else if (unit_done) begin
                    w_next  = S_HOLD;
                    w_latch = 1'b1;
                end
            end
`ifndef FDIV_EARLY_KILL_EN
            S_DRAIN: begin
                if (unit_done) begin
                    w_next = S_IDLE;
                end
            end
`endif
            S_HOLD: begin
                // Squash and claim both invalidate; a squash simultaneous
                // with claim therefore never leaves a valid result behind.
                if (w_sq_resp || claim) begin
                    w_next = S_IDLE;
                    w_clr  = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_resp_new       = '0;
        w_resp_new.opid  = r_unit_op.opid;
        w_resp_new.brid  = r_unit_op.brid;
        w_resp_new.ldid  = r_unit_op.ldid;
        w_resp_new.stid  = r_unit_op.stid;
        w_resp_new.pc    = r_unit_op.pc;
        w_resp_new.pat   = r_unit_op.pat;
        w_resp_new.delta = r_unit_op.delta;
        w_resp_new.prda  = r_unit_op.prda[1];
        w_resp_new.npc   = r_unit_op.base + r_unit_op.delta;
        w_resp_new.prdv  = unit_value;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_unit_op <= '0;
            r_resp    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_unit_op <= req[w_grant_idx];
                r_rr_ptr  <= w_rr_next;
            end
            if (w_latch) begin
                r_resp <= w_resp_new;
            end else if (w_clr) begin
                r_resp.opid <= '0;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE) ? w_grant : '0;
    assign unit_start = (r_state == S_START);
    assign unit_op    = r_unit_op;
    assign resp       = r_resp;

`ifdef FDIV_EARLY_KILL_EN
    assign unit_kill = ((r_state == S_START) || (r_state == S_BUSY)) & w_sq_op;
`else
    assign unit_kill = 1'b0;
`endif

    assign w_unused = ^{redir.opid[14:c_lw], redir.topid[15:c_lw]};

endmodule

`default_nettype wire

// File: tb/tb_fpu_div_ctrl.sv
// ============================================================================
//  Module   : tb_fpu_div_ctrl
//  Purpose  : Directed self-checking bench for fpu_div_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fpu_div_ctrl;
    import fpu_div_pkg::*;

    localparam int NREQ = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    red_bundle_t            redir;
    logic [NREQ-1:0]        req_valid;
    reg_bundle_t [NREQ-1:0] req;
    logic [NREQ-1:0]        req_ready;
    logic                   unit_start;
    reg_bundle_t            unit_op;
    logic                   unit_done;
    logic [63:0]            unit_value;
    logic                   unit_kill;
    logic                   claim;
    exe_bundle_t            resp;

    int n_vec = 0;
    int n_err = 0;

    fpu_div_ctrl #(.NREQ(NREQ), .OPSZ(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .redir      (redir),
        .req_valid  (req_valid),
        .req        (req),
        .req_ready  (req_ready),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .unit_done  (unit_done),
        .unit_value (unit_value),
        .unit_kill  (unit_kill),
        .claim      (claim),
        .resp       (resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic mk_req(input int lane, input logic [15:0] opid);
        req[lane].opid    = opid;
        req[lane].brid    = 8'(lane + 1);
        req[lane].ldid    = 8'h33;
        req[lane].stid    = 8'h44;
        req[lane].pc      = 64'hA000 + 64'(lane);
        req[lane].pat     = 8'h5A;
        req[lane].delta   = {48'h0, opid};
        req[lane].base    = 64'h0000_1000_0000_0000;
        req[lane].prda[1] = 8'h2A;
        req[lane].prda[0] = 8'h11;
    endtask

    task automatic run_rr(input logic [1:0] exp_g, input logic [15:0] exp_op,
                          input logic [63:0] val, input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(exp_g));
        tick();
        chk({tag, "_start"}, 64'(unit_start), 64'h1);
        chk({tag, "_unit_op"}, 64'(unit_op.opid), 64'(exp_op));
        tick();
        unit_done  = 1'b1;
        unit_value = val;
        tick();
        unit_done  = 1'b0;
        chk({tag, "_resp_opid"}, 64'(resp.opid), 64'(exp_op));
        chk({tag, "_resp_prdv"}, resp.prdv, val);
        claim = 1'b1;
        tick();
        claim = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        redir      = '0;
        req_valid  = '0;
        req        = '0;
        unit_done  = 1'b0;
        unit_value = '0;
        claim      = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready",  64'(req_ready),    64'h0);
        chk("rst_start",  64'(unit_start),   64'h0);
        chk("rst_kill",   64'(unit_kill),    64'h0);
        chk("rst_op",     64'(unit_op.opid), 64'h0);
        chk("rst_op_pc",  unit_op.pc,        64'h0);
        chk("rst_resp",   64'(resp.opid),    64'h0);
        chk("rst_prdv",   resp.prdv,         64'h0);
        rst = 1'b0;

        // Single op, done 10 cycles after start
        mk_req(0, 16'h8005);
        req_valid = 2'b01;
        settle();
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        chk("t1_start", 64'(unit_start), 64'h1);
        chk("t1_unit_op", 64'(unit_op.opid), 64'h8005);
        tick();
        chk("t1_start_pulse", 64'(unit_start), 64'h0);
        repeat (8) tick();
        chk("t1_no_early_resp", 64'(resp.opid), 64'h0);
        tick();
        unit_done  = 1'b1;
        unit_value = 64'h4000_0000_0000_0000;
        settle();
        chk("t1_resp_latency", 64'(resp.opid), 64'h0);
        tick();
        unit_done = 1'b0;
        chk("t1_resp_opid", 64'(resp.opid), 64'h8005);
        chk("t1_resp_prdv", resp.prdv, 64'h4000_0000_0000_0000);
        chk("t1_resp_npc",  resp.npc,  64'h0000_1000_0000_8005);
        chk("t1_resp_prda", 64'(resp.prda), 64'h2A);
        chk("t1_resp_pc",   resp.pc,   64'hA000);
        req_valid = 2'b01;
        settle();
        chk("t1_hold_ready", 64'(req_ready), 64'h0);
        req_valid = 2'b00;
        claim = 1'b1;
        tick();
        claim = 1'b0;
        req_valid = 2'b01;
        settle();
        chk("t1_idle_after_claim", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin with both lanes asserting continuously
        mk_req(0, 16'h8010);
        mk_req(1, 16'h8011);
        req_valid = 2'b11;
        settle();
        run_rr(2'b01, 16'h8010, 64'h1111, "rr0");
        run_rr(2'b10, 16'h8011, 64'h2222, "rr1");
        run_rr(2'b01, 16'h8010, 64'h3333, "rr2");
        run_rr(2'b10, 16'h8011, 64'h4444, "rr3");
        req_valid = 2'b00;

        // Squash while BUSY
        mk_req(0, 16'h8005);
        req_valid = 2'b01;
        settle();
        tick();
        req_valid = 2'b00;
        tick();
        redir.opid  = 16'h8003;
        redir.topid = 16'h8000;
        settle();
`ifdef FDIV_EARLY_KILL_EN
        chk("t3_kill", 64'(unit_kill), 64'h1);
        tick();
        redir = '0;
        mk_req(0, 16'h8002);
        req_valid = 2'b01;
        settle();
        chk("t3_idle", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
`else
        chk("t3_kill", 64'(unit_kill), 64'h0);
        tick();
        redir = '0;
        mk_req(0, 16'h8002);
        req_valid = 2'b01;
        settle();
        chk("t3_drain_ready", 64'(req_ready), 64'h0);
        unit_done  = 1'b1;
        unit_value = 64'hDEAD;
        tick();
        unit_done = 1'b0;
        chk("t3_no_resp", resp.prdv, 64'h4444);
        chk("t3_idle", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
`endif
        settle();

        // Squash in HOLD together with claim
        mk_req(0, 16'h8007);
        req_valid = 2'b01;
        settle();
        chk("t4_ready_wrap", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        tick();
        unit_done  = 1'b1;
        unit_value = 64'h3FF0_0000_0000_0000;
        tick();
        unit_done = 1'b0;
        chk("t4_resp_opid", 64'(resp.opid), 64'h8007);
        redir.opid  = 16'h8006;
        redir.topid = 16'h8000;
        claim = 1'b1;
        tick();
        claim = 1'b0;
        redir = '0;
        chk("t4_resp_cleared", 64'(resp.opid), 64'h0);
        req_valid = 2'b01;
        settle();
        chk("t4_idle", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        // Age compare across the 6-bit wrap
        redir.opid  = 16'h803F;
        redir.topid = 16'h803E;
        mk_req(0, 16'h8001);
        req_valid = 2'b01;
        settle();
        chk("t5_wrap_squashed", 64'(req_ready), 64'h0);
        mk_req(0, 16'h803F);
        settle();
        chk("t5_wrap_kept", 64'(req_ready), 64'h1);
        redir = '0;
        mk_req(0, 16'h0005);
        settle();
        chk("t5_invalid_opid", 64'(req_ready), 64'h0);
        req_valid = 2'b00;

        // Squashed lane skipped, then reset mid-BUSY
        redir.opid  = 16'h8003;
        redir.topid = 16'h8000;
        mk_req(0, 16'h8002);
        mk_req(1, 16'h8009);
        req_valid = 2'b10;
        settle();
        chk("t6_lane1_only", 64'(req_ready), 64'h0);
        req_valid = 2'b11;
        settle();
        chk("t6_skip_squashed", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        redir = '0;
        chk("t6_start", 64'(unit_start), 64'h1);
        chk("t6_unit_op", 64'(unit_op.opid), 64'h8002);
        tick();
        chk("t6_busy", 64'(unit_start), 64'h0);
        rst = 1'b1;
        tick();
        chk("t6_rst_ready", 64'(req_ready),    64'h0);
        chk("t6_rst_start", 64'(unit_start),   64'h0);
        chk("t6_rst_kill",  64'(unit_kill),    64'h0);
        chk("t6_rst_op",    64'(unit_op.opid), 64'h0);
        chk("t6_rst_resp",  64'(resp.opid),    64'h0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
